// File: rtl/serial_cmd_pkg.sv
// Shared encodings for the serial command frame decoder, its encoder
// and bench: FSM states, frame field indices, error codes, framing bytes.
package serial_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        F_SOF0    = 3'd0,
        F_SOF1    = 3'd1,
        F_SPACE   = 3'd2,
        F_LEN     = 3'd3,
        F_PAYLOAD = 3'd4,
        F_CSUM    = 3'd5,
        F_EOF0    = 3'd6,
        F_EOF1    = 3'd7
    } field_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_SOF      = 3'd1;
    localparam logic [2:0] ERR_SPACE    = 3'd2;
    localparam logic [2:0] ERR_LEN      = 3'd3;
    localparam logic [2:0] ERR_CSUM     = 3'd4;
    localparam logic [2:0] ERR_EOF      = 3'd5;
    localparam logic [2:0] ERR_UNDERRUN = 3'd6;

    localparam logic [7:0] DEF_SOF_BYTE   = 8'hFF;
    localparam logic [7:0] DEF_SPACE_BYTE = 8'h00;
    localparam logic [7:0] DEF_EOF_BYTE   = 8'hEE;

endpackage

// File: rtl/serial_cmd_field_checker.sv
// Combinational pass/fail and error code for one received frame byte,
// selected by the field the decoder is currently expecting.
module serial_cmd_field_checker
    import serial_cmd_pkg::*;
#(
    parameter int         MAX_PAYLOAD_BYTES = 16,
    parameter logic [7:0] SOF_BYTE          = DEF_SOF_BYTE,
    parameter logic [7:0] SPACE_BYTE        = DEF_SPACE_BYTE,
    parameter logic [7:0] EOF_BYTE          = DEF_EOF_BYTE
) (
    input  field_t     field,
    input  logic [7:0] data,
    input  logic [7:0] csum,
    output logic       pass,
    output logic [2:0] err_code
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD_BYTES);

    always_comb begin
        pass     = 1'b1;
        err_code = ERR_NONE;
        unique case (field)
            F_SOF0, F_SOF1: begin
                if (data != SOF_BYTE) begin
                    pass     = 1'b0;
                    err_code = ERR_SOF;
                end
            end
            F_SPACE: begin
                if (data != SPACE_BYTE) begin
                    pass     = 1'b0;
                    err_code = ERR_SPACE;
                end
            end
            F_LEN: begin
                if (data == 8'd0 || data > MAX_LEN) begin
                    pass     = 1'b0;
                    err_code = ERR_LEN;
                end
            end
            F_PAYLOAD: pass = 1'b1;
            F_CSUM: begin
                if (data != csum) begin
                    pass     = 1'b0;
                    err_code = ERR_CSUM;
                end
            end
            F_EOF0, F_EOF1: begin
                if (data != EOF_BYTE) begin
                    pass     = 1'b0;
                    err_code = ERR_EOF;
                end
            end
        endcase
    end

endmodule

// File: rtl/serial_cmd_frame_decoder.sv
// Drains one framed command from the UART byte FIFO, validates framing,
// unpacks the payload and reports through a processed/ack handshake.
module serial_cmd_frame_decoder
    import serial_cmd_pkg::*;
#(
    parameter int         DATA_WIDTH        = 8,
    parameter int         MAX_PAYLOAD_BYTES = 16,
    parameter logic [7:0] SOF_BYTE          = DEF_SOF_BYTE,
    parameter logic [7:0] SPACE_BYTE        = DEF_SPACE_BYTE,
    parameter logic [7:0] EOF_BYTE          = DEF_EOF_BYTE,
    parameter bit         CHECKSUM_EN       = 1'b0,
    parameter bit         FLUSH_ON_ERROR    = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_ready,
    input  logic                           fifo_empty,
    input  logic [DATA_WIDTH-1:0]          data,
    input  logic                           cmd_processed_received,
    output logic                           cmd_read_clk,
    output logic                           cmd_processed,
    output logic                           cmd_decode_success,
    output logic [2:0]                     cmd_error_code,
    output logic [7:0]                     cmd_payload_len,
    output logic [7:0]                     cmd_bytes_processed,
    output logic [8*MAX_PAYLOAD_BYTES-1:0] cmd_payload
);

    localparam field_t PAY_NEXT = CHECKSUM_EN ? F_CSUM : F_EOF0;

    state_t     state, state_nxt;
    field_t     field;
    logic       ready_q;
    logic       start;
    logic       flush_gap;
    logic       chk_pass;
    logic [2:0] chk_err;
    logic [7:0] csum;
    logic [7:0] pay_idx;
    logic [7:0] bytes_inc;

    assign start     = cmd_ready & ~ready_q;
    assign bytes_inc = (cmd_bytes_processed == 8'hFF) ? 8'hFF
                     : cmd_bytes_processed + 8'd1;

    serial_cmd_field_checker #(
        .MAX_PAYLOAD_BYTES(MAX_PAYLOAD_BYTES),
        .SOF_BYTE         (SOF_BYTE),
        .SPACE_BYTE       (SPACE_BYTE),
        .EOF_BYTE         (EOF_BYTE)
    ) u_chk (
        .field   (field),
        .data    (data),
        .csum    (csum),
        .pass    (chk_pass),
        .err_code(chk_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        cmd_read_clk = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_READ;
            S_READ: begin
                if (fifo_empty) begin
                    state_nxt = S_DONE;
                end else begin
                    cmd_read_clk = 1'b1;
                    state_nxt    = S_LATCH;
                end
            end
            S_LATCH: begin
                if (!chk_pass)
                    state_nxt = FLUSH_ON_ERROR ? S_FLUSH : S_DONE;
                else if (field == F_EOF1)
                    state_nxt = S_DONE;
                else
                    state_nxt = S_READ;
            end
            S_FLUSH: begin
                if (!flush_gap) begin
                    if (fifo_empty) state_nxt = S_DONE;
                    else            cmd_read_clk = 1'b1;
                end
            end
            S_DONE: begin
                if (cmd_processed && cmd_processed_received)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q             <= 1'b0;
            field               <= F_SOF0;
            flush_gap           <= 1'b0;
            csum                <= 8'd0;
            pay_idx             <= 8'd0;
            cmd_processed       <= 1'b0;
            cmd_decode_success  <= 1'b0;
            cmd_error_code      <= ERR_NONE;
            cmd_payload_len     <= 8'd0;
            cmd_bytes_processed <= 8'd0;
            cmd_payload         <= '0;
        end else begin
            ready_q <= cmd_ready;
            if (cmd_read_clk) cmd_bytes_processed <= bytes_inc;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        field               <= F_SOF0;
                        csum                <= 8'd0;
                        pay_idx             <= 8'd0;
                        cmd_error_code      <= ERR_NONE;
                        cmd_decode_success  <= 1'b0;
                        cmd_bytes_processed <= 8'd0;
                        cmd_payload         <= '0;
                    end
                end
                S_READ: if (fifo_empty) cmd_error_code <= ERR_UNDERRUN;
                S_LATCH: begin
                    flush_gap <= 1'b0;
                    if (!chk_pass) begin
                        cmd_error_code <= chk_err;
                    end else begin
                        unique case (field)
                            F_SOF0:  field <= F_SOF1;
                            F_SOF1:  field <= F_SPACE;
                            F_SPACE: field <= F_LEN;
                            F_LEN: begin
                                field           <= F_PAYLOAD;
                                cmd_payload_len <= data;
                                csum            <= data;
                                pay_idx         <= 8'd0;
                            end
                            F_PAYLOAD: begin
                                for (int i = 0; i < MAX_PAYLOAD_BYTES; i++)
                                    if (pay_idx == 8'(i))
                                        cmd_payload[8*i +: 8] <= data;
                                csum    <= csum ^ data;
                                pay_idx <= pay_idx + 8'd1;
                                if (pay_idx + 8'd1 == cmd_payload_len)
                                    field <= PAY_NEXT;
                            end
                            F_CSUM: field <= F_EOF0;
                            F_EOF0: field <= F_EOF1;
                            F_EOF1: cmd_decode_success <= 1'b1;
                        endcase
                    end
                end
                S_FLUSH: flush_gap <= ~flush_gap;
                S_DONE: begin
                    if (!cmd_processed) begin
                        cmd_processed <= 1'b1;
                    end else if (cmd_processed_received) begin
                        cmd_processed      <= 1'b0;
                        cmd_decode_success <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cmd_frame_decoder.sv
// Directed and randomised frames checked against a frame-level reference
// model; one decoder without and one with the checksum byte.
`timescale 1ns/1ps
module tb_serial_cmd_frame_decoder;
    import serial_cmd_pkg::*;

    localparam int MAXP = 16;

    typedef logic [7:0] bq_t [$];
    typedef struct packed {
        logic                succ;
        logic [2:0]          err;
        logic [7:0]          len;
        logic [7:0]          bytes;
        logic [8*MAXP-1:0]   pl;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] rdy = 2'b00;
    logic [1:0] ack = 2'b00;
    logic [1:0] rclk, proc, succ;
    logic [2:0] err [2];
    logic [7:0] len [2];
    logic [7:0] bytes [2];
    logic [8*MAXP-1:0] pl [2];

    logic [7:0] mem [0:16383];
    int rd_ptr = 0;
    int wr_ptr = 0;
    logic [7:0] fdata = 8'd0;
    logic fifo_empty;

    int tests = 0;
    int fails = 0;
    logic [7:0] prev_len [2];

    assign fifo_empty = (rd_ptr == wr_ptr);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if ((|rclk) && rd_ptr != wr_ptr) begin
            fdata  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    serial_cmd_frame_decoder #(.MAX_PAYLOAD_BYTES(MAXP)) dut0 (
        .clk(clk), .rst(rst), .cmd_ready(rdy[0]), .fifo_empty(fifo_empty),
        .data(fdata), .cmd_processed_received(ack[0]),
        .cmd_read_clk(rclk[0]), .cmd_processed(proc[0]),
        .cmd_decode_success(succ[0]), .cmd_error_code(err[0]),
        .cmd_payload_len(len[0]), .cmd_bytes_processed(bytes[0]),
        .cmd_payload(pl[0])
    );

    serial_cmd_frame_decoder #(
        .MAX_PAYLOAD_BYTES(MAXP), .CHECKSUM_EN(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .cmd_ready(rdy[1]), .fifo_empty(fifo_empty),
        .data(fdata), .cmd_processed_received(ack[1]),
        .cmd_read_clk(rclk[1]), .cmd_processed(proc[1]),
        .cmd_decode_success(succ[1]), .cmd_error_code(err[1]),
        .cmd_payload_len(len[1]), .cmd_bytes_processed(bytes[1]),
        .cmd_payload(pl[1])
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks the byte list field by field from the frame rules.
    function automatic res_t ref_decode(input bq_t b, input bit cs,
                                        input logic [7:0] plen);
        res_t r;
        int p, l, n;
        logic [7:0] v, x;
        bit done;
        r = '0; r.len = plen;
        p = 0; l = 0; x = 8'd0; done = 1'b0; n = b.size();
        while (!done && r.err == ERR_NONE) begin
            if (p >= n) begin
                r.err = ERR_UNDERRUN;
            end else begin
                v = b[p];
                p++;
                if (p <= 2) begin
                    if (v != DEF_SOF_BYTE) r.err = ERR_SOF;
                end else if (p == 3) begin
                    if (v != DEF_SPACE_BYTE) r.err = ERR_SPACE;
                end else if (p == 4) begin
                    if (v == 8'd0 || int'(v) > MAXP) r.err = ERR_LEN;
                    else begin l = int'(v); x = v; r.len = v; end
                end else if (p <= 4 + l) begin
                    r.pl[(p-5)*8 +: 8] = v;
                    x = x ^ v;
                end else if (cs && p == 5 + l) begin
                    if (v != x) r.err = ERR_CSUM;
                end else if (v != DEF_EOF_BYTE) begin
                    r.err = ERR_EOF;
                end else if (p == 6 + l + int'(cs)) begin
                    done = 1'b1;
                end
            end
        end
        r.succ  = done;
        r.bytes = 8'(p);
        if (r.err != ERR_NONE && r.err != ERR_UNDERRUN)
            r.bytes = (n > 255) ? 8'hFF : 8'(n);
        return r;
    endfunction

    function automatic bq_t mk_frame(input int l, input bit cs);
        bq_t q;
        logic [7:0] x, v;
        q = '{DEF_SOF_BYTE, DEF_SOF_BYTE, DEF_SPACE_BYTE, 8'(l)};
        x = 8'(l);
        for (int i = 0; i < l; i++) begin
            v = 8'($urandom);
            q.push_back(v);
            x = x ^ v;
        end
        if (cs) q.push_back(x);
        q.push_back(DEF_EOF_BYTE);
        q.push_back(DEF_EOF_BYTE);
        return q;
    endfunction

    task automatic run_frame(input int u, input bq_t b, input int hold,
                             input bit keep_ready);
        res_t e;
        int cyc, n0;
        bit seen;
        e = ref_decode(b, u == 1, prev_len[u]);
        @(negedge clk);
        n0 = rd_ptr;
        foreach (b[i]) begin
            mem[wr_ptr] = b[i];
            wr_ptr++;
        end
        rdy[u] = 1'b1;
        @(posedge clk);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = proc[u];
        end
        check("done_seen", 128'(seen), 128'd1);
        if (e.succ) check("latency", 128'(cyc), 128'(2*b.size()+1));
        if (!keep_ready) rdy[u] = 1'b0;
        @(negedge clk);
        check("success", 128'(succ[u]), 128'(e.succ));
        check("err_code", 128'(err[u]), 128'(e.err));
        check("payload_len", 128'(len[u]), 128'(e.len));
        check("bytes", 128'(bytes[u]), 128'(e.bytes));
        check("payload", 128'(pl[u]), 128'(e.pl));
        check("fifo_pops", 128'(rd_ptr - n0), 128'(b.size()));
        repeat (hold) begin
            @(negedge clk);
            check("hold_proc", 128'(proc[u]), 128'd1);
            check("hold_succ", 128'(succ[u]), 128'(e.succ));
            check("hold_err", 128'(err[u]), 128'(e.err));
            check("hold_bytes", 128'(bytes[u]), 128'(e.bytes));
        end
        ack[u] = 1'b1;
        @(negedge clk);
        ack[u] = 1'b0;
        check("ack_proc", 128'(proc[u]), 128'd0);
        check("ack_succ", 128'(succ[u]), 128'd0);
        check("payload_kept", 128'(pl[u]), 128'(e.pl));
        prev_len[u] = e.len;
        if (keep_ready) begin
            repeat (10) @(negedge clk);
            check("no_retrigger", 128'(proc[u]), 128'd0);
            rdy[u] = 1'b0;
        end
    endtask

    task automatic check_zero(input int u, input string tag);
        check({tag, "_proc"}, 128'(proc[u]), 128'd0);
        check({tag, "_succ"}, 128'(succ[u]), 128'd0);
        check({tag, "_err"}, 128'(err[u]), 128'd0);
        check({tag, "_len"}, 128'(len[u]), 128'd0);
        check({tag, "_bytes"}, 128'(bytes[u]), 128'd0);
        check({tag, "_pl"}, 128'(pl[u]), 128'd0);
        check({tag, "_rclk"}, 128'(rclk[u]), 128'd0);
    endtask

    initial begin
        bq_t f;
        int u, l, kind, pos;
        prev_len[0] = 8'd0;
        prev_len[1] = 8'd0;
        repeat (3) @(negedge clk);
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        rst = 1'b1;
        @(negedge clk);

        f = '{8'hFF, 8'hFF, 8'h00, 8'h06, 8'h11, 8'h22, 8'h33,
              8'h44, 8'h55, 8'h66, 8'hEE, 8'hEE};
        run_frame(0, f, 0, 1'b1);
        check("tp_len6", 128'(len[0]), 128'd6);
        check("tp_pl", 128'(pl[0]), 128'h6655_4433_2211);

        f[0] = 8'hFE;
        run_frame(0, f, 0, 1'b0);

        f = mk_frame(17, 1'b0);
        run_frame(0, f, 0, 1'b0);
        run_frame(0, mk_frame(MAXP, 1'b0), 0, 1'b0);
        run_frame(0, mk_frame(1, 1'b0), 0, 1'b0);

        f = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'hA5, 8'h5A, 8'hFD, 8'hEE, 8'hEE};
        run_frame(1, f, 0, 1'b0);
        f[6] = 8'h00;
        run_frame(1, f, 0, 1'b0);

        f = '{8'hFF, 8'hFF, 8'h00, 8'h04, 8'h01, 8'h02};
        run_frame(0, f, 0, 1'b0);

        f = '{8'hFE};
        for (int i = 0; i < 299; i++) f.push_back(8'($urandom));
        run_frame(0, f, 0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            u = int'($urandom_range(0, 1));
            l = int'($urandom_range(1, MAXP));
            f = mk_frame(l, u == 1);
            kind = int'($urandom_range(0, 6));
            case (kind)
                1: begin
                    pos = int'($urandom_range(0, f.size() - 1));
                    f[pos] = f[pos] ^ 8'($urandom_range(1, 255));
                end
                2: repeat ($urandom_range(1, f.size() - 1)) void'(f.pop_back());
                3: f[3] = ($urandom_range(0, 1) != 0) ? 8'h00
                        : 8'($urandom_range(MAXP + 1, 255));
                default: ;
            endcase
            run_frame(u, f, 0, 1'b0);
        end

        f = mk_frame(8, 1'b0);
        @(negedge clk);
        foreach (f[i]) begin
            mem[wr_ptr] = f[i];
            wr_ptr++;
        end
        rdy[0] = 1'b1;
        repeat (12) @(negedge clk);
        rst = 1'b0;
        rdy[0] = 1'b0;
        #1;
        check_zero(0, "midrst");
        @(negedge clk);
        wr_ptr = rd_ptr;
        rst = 1'b1;
        prev_len[0] = 8'd0;
        prev_len[1] = 8'd0;
        repeat (5) @(negedge clk);
        check("midrst_idle", 128'(proc[0]), 128'd0);

        run_frame(0, mk_frame(5, 1'b0), 20, 1'b0);
        run_frame(1, mk_frame(3, 1'b1), 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
